// File: rtl/spike_event_logger_pkg.sv
// Shared constants and helpers for the spike event logger.
// Optional per-neuron totals are enabled with SPIKE_EVENT_COUNT_EN.
package snn_event_pkg;
  localparam int TS_W_DEF  = 8;
  localparam int DEPTH_DEF = 16;
  localparam int N_L1_DEF  = 8;
  localparam int N_OUT_DEF = 2;

  localparam int OUT_LSB = 0;
  localparam int L1_LSB  = N_OUT_DEF;
  localparam int TS_LSB  = N_OUT_DEF + N_L1_DEF;

  function automatic int evt_width(
    input int ts_w,
    input int n_l1,
    input int n_out
  );
    return ts_w + n_l1 + n_out;
  endfunction
endpackage

// File: rtl/spike_event_logger_if.sv
// Valid/ready event stream between the logger and its readout.
// Master presents head event, slave accepts it with ready.
interface spike_event_logger_if #(
  parameter int W = 18
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/spike_event_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Accepts push and pop together when full; head reads 0 when empty.
module spike_event_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/spike_event_logger.sv
// Spike edge detector with time-stamped event FIFO and drop tracking.
// Define SPIKE_EVENT_COUNT_EN to add per-output-neuron spike totals.
module spike_event_logger
  import snn_event_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int N_L1  = N_L1_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    delay_clk,
  input  logic [N_L1-1:0]         output_spikes_layer1,
  input  logic [N_OUT-1:0]        output_spikes,
  spike_event_logger_if.master    evt,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic [7:0]              drop_count
`ifdef SPIKE_EVENT_COUNT_EN
  ,
  output logic [N_OUT*16-1:0]     spike_totals
`endif
);
  localparam int SW = N_L1 + N_OUT;
  localparam int EW = evt_width(TS_W, N_L1, N_OUT);

  logic [SW-1:0]   s1_q, s2_q;
  logic            dclk1_q, dclk2_q;
  logic [TS_W-1:0] ts_q;
  logic            ovf_q;
  logic [7:0]      drop_q;
  logic [SW-1:0]   edges;
  logic            tick;
  logic            push_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic            drop;
  logic [EW-1:0]   wdata;

  assign edges    = s1_q & ~s2_q;
  assign tick     = dclk1_q & ~dclk2_q;
  assign push_req = enable & (|edges);
  assign drop     = push_req & fifo_full & ~evt.ready;
  assign wdata    = {ts_q, edges};

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      dclk1_q <= 1'b0;
      dclk2_q <= 1'b0;
    end else begin
      s1_q    <= {output_spikes_layer1, output_spikes};
      s2_q    <= s1_q;
      dclk1_q <= delay_clk;
      dclk2_q <= dclk1_q;
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      ts_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (clear) begin
      ts_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (enable && tick) ts_q <= ts_q + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  spike_event_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (system_clock),
    .rst_n   (reset),
    .clr_i   (clear),
    .push_i  (push_req),
    .pop_i   (evt.ready),
    .wdata_i (wdata),
    .rdata_o (evt.data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign evt.valid  = ~fifo_empty;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

`ifdef SPIKE_EVENT_COUNT_EN
  logic [N_OUT-1:0][15:0] tot_q;

  // Totals see every enabled edge, even ones the FIFO drops.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      tot_q <= '0;
    end else if (clear) begin
      tot_q <= '0;
    end else if (enable) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (edges[OUT_LSB+i] && tot_q[i] != 16'hFFFF)
          tot_q[i] <= tot_q[i] + 1'b1;
      end
    end
  end

  assign spike_totals = tot_q;
`endif
endmodule

// File: tb/tb_spike_event_logger.sv
// Randomized and directed bench for spike_event_logger.
// Build with SPIKE_EVENT_COUNT_EN to also check spike_totals.
module tb_spike_event_logger;
  import snn_event_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       dclk = 1'b0;
  logic [7:0] l1 = '0;
  logic [1:0] sp = '0;
  logic [4:0] fifo_count;
  logic       ovf;
  logic [7:0] drops;
`ifdef SPIKE_EVENT_COUNT_EN
  logic [31:0] totals;
`endif

  spike_event_logger_if #(.W(EW)) evt();

  spike_event_logger dut (
    .system_clock         (clk),
    .reset                (rst_n),
    .enable               (en),
    .clear                (clr),
    .delay_clk            (dclk),
    .output_spikes_layer1 (l1),
    .output_spikes        (sp),
    .evt                  (evt.master),
    .fifo_count           (fifo_count),
    .overflow             (ovf),
    .drop_count           (drops)
`ifdef SPIKE_EVENT_COUNT_EN
    ,
    .spike_totals         (totals)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  // Reference: event queue plus the inputs seen one and two clocks ago.
  logic [EW-1:0] mq[$];
  int   m_ts;
  bit   m_ovf;
  int   m_drops;
  int   m_tot[2];
  logic [9:0] h1, h2;
  bit   h1d, h2d;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts = 0; m_ovf = 0; m_drops = 0;
    m_tot[0] = 0; m_tot[1] = 0;
    h1 = '0; h2 = '0; h1d = 0; h2d = 0;
  endtask

  task automatic model_step();
    logic [9:0] e;
    bit t, pop;
    int n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e = h1 & ~h2;
    t = h1d & ~h2d;
    if (clr) begin
      mq.delete();
      m_ts = 0; m_ovf = 0; m_drops = 0;
      m_tot[0] = 0; m_tot[1] = 0;
    end else begin
      n = mq.size();
      pop = evt.ready && n > 0;
      if (pop) void'(mq.pop_front());
      if (en && e != 0) begin
        if (n == DEPTH && !pop) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          mq.push_back({m_ts[7:0], e});
        end
      end
      if (en && t) m_ts = (m_ts + 1) % 256;
      if (en) for (int i = 0; i < 2; i++)
        if (e[i] && m_tot[i] < 65535) m_tot[i]++;
    end
    h2 = h1; h2d = h1d;
    h1 = {l1, sp}; h1d = dclk;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      chk("valid", 32'(evt.valid), 32'(mq.size() > 0));
      chk("data", 32'(evt.data),
          (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      chk("count", 32'(fifo_count), 32'(mq.size()));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("drops", 32'(drops), 32'(m_drops));
`ifdef SPIKE_EVENT_COUNT_EN
      chk("totals", totals, {m_tot[1][15:0], m_tot[0][15:0]});
`endif
    end
  end

  initial begin
    int prev, cur;
    evt.ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(evt.valid), 0);
    chk("rst_data", 32'(evt.data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_drops", 32'(drops), 0);
    cyc(2);
    rst_n = 1'b1;
    cmp_on = 1;

    // single held spike gives one event, two cycles after the rise
    en = 1; cyc(2);
    sp = 2'b01; cyc(1);
    chk("t1_lat1", 32'(evt.valid), 0);
    cyc(1);
    chk("t1_lat2", 32'(evt.valid), 1);
    chk("t1_data", 32'(evt.data), 32'h00001);
    chk("t1_count", 32'(fifo_count), 1);
    cyc(3);
    sp = 2'b00; cyc(3);
    chk("t1_once", 32'(fifo_count), 1);
    evt.ready = 1; cyc(2); evt.ready = 0;

    // three ticks, then spike coincident with a fourth tick
    for (int i = 0; i < 3; i++) begin
      dclk = 1; cyc(2);
      dclk = 0; cyc(2);
    end
    dclk = 1; l1 = 8'h08; cyc(1);
    l1 = 8'h00; cyc(1);
    chk("t2_data", 32'(evt.data), 32'h00C20);
    dclk = 0;
    evt.ready = 1; cyc(1); evt.ready = 0;
    sp = 2'b01; cyc(2);
    chk("t2_ts4", 32'(evt.data), 32'h01001);
    sp = 2'b00;
    evt.ready = 1; cyc(3); evt.ready = 0;

    // overfill with 20 edges
    for (int i = 0; i < 20; i++) begin
      sp = 2'b01; dclk = 1; cyc(1);
      sp = 2'b00; dclk = 0; cyc(1);
    end
    cyc(2);
    chk("t3_count", 32'(fifo_count), 16);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_drops", 32'(drops), 4);

    // push and pop together while full
    sp = 2'b01; cyc(1);
    evt.ready = 1; cyc(1);
    evt.ready = 0; sp = 2'b00;
    chk("t4_count", 32'(fifo_count), 16);
    chk("t4_drops", 32'(drops), 4);
    cyc(2);
    evt.ready = 1;
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      cur = int'(evt.data[17:10]);
      if (i > 0) chk("t4_order", 32'(cur > prev), 1);
      prev = cur;
      cyc(1);
    end
    chk("t4_empty", 32'(evt.valid), 0);
    evt.ready = 0;

    // held spike across disable/re-enable: no event, ts frozen
    en = 0; sp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      dclk = 1; cyc(2);
      dclk = 0; cyc(2);
    end
    en = 1; cyc(4);
    chk("t5_noevt", 32'(evt.valid), 0);
    sp = 2'b00; cyc(2);
    sp = 2'b01; cyc(2);
    chk("t5_ts", 32'(evt.data[17:10]), 32'(m_ts));
    sp = 2'b00;
    evt.ready = 1; cyc(3); evt.ready = 0;

    // asynchronous reset with five events queued
    for (int i = 0; i < 5; i++) begin
      sp = 2'b01; dclk = 1; cyc(1);
      sp = 2'b00; dclk = 0; cyc(1);
    end
    chk("t6_five", 32'(fifo_count), 5);
    sp = 2'b01; cyc(1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", 32'(evt.valid), 0);
    chk("t6_data", 32'(evt.data), 0);
    chk("t6_count", 32'(fifo_count), 0);
    chk("t6_ovf", 32'(ovf), 0);
    chk("t6_drops", 32'(drops), 0);
`ifdef SPIKE_EVENT_COUNT_EN
    chk("t6_totals", totals, 0);
`endif
    cyc(2);
    sp = 2'b00; cyc(1);
    rst_n = 1'b1;
    cyc(2);
    sp = 2'b01; cyc(2);
    chk("t6_ts0", 32'(evt.data), 32'h00001);
    sp = 2'b00;
    evt.ready = 1; cyc(3); evt.ready = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 8) != 0;
      clr = ($urandom % 64) == 0;
      evt.ready = ($urandom % 3) == 0;
      dclk = $urandom;
      sp = 2'($urandom & $urandom);
      l1 = 8'($urandom & $urandom & $urandom);
      cyc(1);
    end
    clr = 0; en = 1; evt.ready = 0;
    sp = 0; l1 = 0; dclk = 0;
    cyc(2);

    // drop counter saturation and timestamp wrap
    for (int i = 0; i < 290; i++) begin
      sp = 2'b01; dclk = 1; cyc(1);
      sp = 2'b00; dclk = 0; cyc(1);
    end
    cyc(2);
    chk("sat_drops", 32'(drops), 255);

    // clear with a push landing on the same cycle
    sp = 2'b01; cyc(1);
    clr = 1; cyc(1);
    clr = 0; sp = 2'b00;
    chk("clr_count", 32'(fifo_count), 0);
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_drops", 32'(drops), 0);
    cyc(3);

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_event_logger.md
Name: spike_event_logger

Overview:
- Sits directly downstream of the SNN core in spiking_network_top.
- Consumes output_spikes (layer 2), output_spikes_layer1 and the delay_clk produced by clock_divider.
- Detects new spikes, stamps each one with a time-step counter and buffers the events in a FIFO.
- The readout side (SPI shift-out or a debug port) drains the events through a valid/ready handshake.

Parameters:
- TS_W, 8, timestamp width in bits; counts delay_clk rising edges.
- DEPTH, 16, FIFO depth in events; must be a power of two, ≥2.
- N_L1, 8, number of layer-1 neurons.
- N_OUT, 2, number of output neurons.

Ports:
- system_clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  capture enable; sampled on system_clock.
- clear  in  1  synchronous clear of FIFO, timestamp and flags; has priority over all other activity.
- delay_clk  in  1  time-step clock from clock_divider; treated as a level and sampled in the system_clock domain.
- output_spikes_layer1  in  N_L1  layer-1 spike levels.
- output_spikes  in  N_OUT  output-layer spike levels.
- evt_valid  out  1  FIFO head holds a valid event.
- evt_ready  in  1  consumer accepts the head event.
- evt_data  out  TS_W+N_L1+N_OUT  event word {timestamp, l1_edges, out_edges}; out_edges sit in the LSBs.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when an event is dropped.
- drop_count  out  8  number of dropped events; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous): all of the following are cleared immediately, with no pending write surviving a mid-operation reset:
  - timestamp, read/write pointers, fifo_count, overflow, drop_count;
  - spike history registers and delay_clk history register.
  - Resulting outputs: evt_valid=0, evt_data=0, fifo_count=0, overflow=0, drop_count=0.
- Input stage: spike vectors and delay_clk are registered every cycle (stage S1), regardless of enable. The previous S1 value is held in S2.
- Edge detection: edges = S1 & ~S2, computed bitwise over the concatenated {layer1, out} vector. Only 0→1 transitions count; a level held high produces exactly one event.
- Tick: tick = S1_dclk & ~S2_dclk.
  - If enable=1, the timestamp increments by 1 on a tick.
  - It wraps from 2^TS_W−1 to 0 silently.
  - If enable=0, the timestamp is held.
- Push: when enable=1 and edges≠0, the word {timestamp, edges} is written on that edge.
  - The pre-increment timestamp is used if a tick coincides.
  - Latency: input rises before edge k, is registered at k, pushed at k+1. evt_valid is high from cycle k+1, i.e. 2 cycles.
- enable=0: no pushes. The history registers keep tracking, so re-enabling while a spike is held high produces no spurious event.
- Pop: occurs when evt_valid && evt_ready.
  - evt_data is first-word-fall-through: the head is presented combinationally from the FIFO RAM and is stable while evt_valid=1 and not popped.
  - evt_data shows 0 when empty.
- Full:
  - A push with fifo_count==DEPTH and no pop is dropped. overflow is set and drop_count increments, saturating at 255.
  - A push and a pop on the same cycle while full are both accepted; count is unchanged and no drop occurs.
- Empty: a pop request with evt_valid=0 is ignored. A push and pop on the same cycle while empty is only a push, since the head does not exist yet.
- Pointers wrap modulo DEPTH. fifo_count = wr−rd using one extra bit.
- clear=1:
  - Next cycle: fifo_count=0, evt_valid=0, overflow=0, drop_count=0, timestamp=0.
  - A push or pop on the clear cycle is discarded.
  - History registers are not cleared.

Optional Feature:
- Macro: SPIKE_EVENT_COUNT_EN.
- Defined:
  - Adds output port spike_totals, N_OUT*16 bits.
  - Holds one 16-bit saturating counter per output neuron.
  - A counter increments on each accepted out_edges bit (enable=1), independent of FIFO full.
  - Cleared by reset and by clear.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package snn_event_pkg holds:
  - default constants TS_W_DEF=8, DEPTH_DEF=16;
  - field-offset localparams OUT_LSB=0, L1_LSB=N_OUT, TS_LSB=N_OUT+N_L1;
  - a function computing the event width.
- One sub-module, spike_event_fifo: a generic FWFT sync FIFO providing push/pop/full/empty/count and simultaneous push-pop when full. spike_event_logger contains the edge/tick detect, timestamp and drop logic.

Test Plan:
- Reset then enable=1. Raise output_spikes=2'b01 for 5 cycles. Expect exactly 1 event with data {ts=0, l1=0, out=01}, evt_valid high 2 cycles after the rise, fifo_count=1.
- Apply 3 delay_clk rising edges, then pulse layer1 bit 3 on the same cycle as a 4th tick. Expect event ts=3, l1=8'h08, out=0; timestamp afterwards is 4.
- Hold evt_ready=0 and generate 20 distinct spike edges (DEPTH=16). Expect fifo_count=16, overflow=1, drop_count=4. Drain 16 events in order with increasing ts; then evt_valid=0.
- FIFO full with evt_ready=1 and a new spike edge on the same cycle: fifo_count stays 16 and drop_count is unchanged.
- Set enable=0 and raise output_spikes=2'b10, then re-enable while it is still held. Expect no event and the timestamp frozen during enable=0.
- Assert reset=0 asynchronously mid-burst with the FIFO holding 5 events. Outputs zero immediately; after release, the FIFO is empty and the next spike gets ts=0. With SPIKE_EVENT_COUNT_EN, spike_totals also reads 0.
